tl_punchthrough_responder: RTL and testbench

TileLink-UL slave that terminates the master punch-through port of the bridge emulator: accepts A-channel requests, performs them against a word-addressed on-chip register array, and returns D-channel responses. Lets the emulated tile exercise real memory traffic in RTL simulation without the FireSim bridge. Single-beat only, in-order, with up to 2 outstanding responses.

---
 rtl/tl_pt_pkg.sv | 25 ++
 rtl/tl_pt_resp_queue.sv | 49 ++++
 rtl/tl_punchthrough_responder.sv | 153 +++++++++++++++
 tb/tb_tl_punchthrough_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pt_pkg.sv
// Shared TileLink-UL opcode constants and the queued D-channel response record
// for the punch-through responder.
package tl_pt_pkg;

    localparam logic [2:0] AOpPutFull    = 3'd0;
    localparam logic [2:0] AOpPutPartial = 3'd1;
    localparam logic [2:0] AOpArith      = 3'd2;
    localparam logic [2:0] AOpLogic      = 3'd3;
    localparam logic [2:0] AOpGet        = 3'd4;
    localparam logic [2:0] AOpIntent     = 3'd5;

    localparam logic [2:0] DOpAccessAck     = 3'd0;
    localparam logic [2:0] DOpAccessAckData = 3'd1;
    localparam logic [2:0] DOpHintAck       = 3'd2;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [1:0]  source;
        logic        denied;
        logic        corrupt;
        logic [63:0] data;
    } tl_pt_rsp_t;

endpackage

// File: rtl/tl_pt_resp_queue.sv
// Two-entry in-order FIFO of D-channel responses; the head is always registered so
// a response never bypasses straight from the A channel.
module tl_pt_resp_queue
    import tl_pt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  tl_pt_rsp_t data_i,
    output tl_pt_rsp_t head_o,
    output logic [1:0] count_o
);

    tl_pt_rsp_t entries_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != 2'd2);
        do_pop   = pop_i && (count_q != 2'd0);
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            entries_q[0] <= '0;
            entries_q[1] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                entries_q[wr_ptr_q] <= data_i;
            end
        end
    end

    assign head_o  = entries_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/tl_punchthrough_responder.sv
// TileLink-UL slave backed by a word-addressed 64-bit register array; single-beat,
// in-order, up to two responses outstanding, optional zero-fill after reset.
module tl_punchthrough_responder
    import tl_pt_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        a_valid_i,
    output logic        a_ready_o,
    input  logic [2:0]  a_opcode_i,
    input  logic [2:0]  a_param_i,
    input  logic [3:0]  a_size_i,
    input  logic [1:0]  a_source_i,
    input  logic [31:0] a_address_i,
    input  logic [7:0]  a_mask_i,
    input  logic [63:0] a_data_i,
    input  logic        a_corrupt_i,
    output logic        d_valid_o,
    input  logic        d_ready_i,
    output logic [2:0]  d_opcode_o,
    output logic [1:0]  d_param_o,
    output logic [3:0]  d_size_o,
    output logic [1:0]  d_source_o,
    output logic [2:0]  d_sink_o,
    output logic        d_denied_o,
    output logic [63:0] d_data_o,
    output logic        d_corrupt_o,
    output logic        init_done_o
);

    localparam int unsigned IdxW      = $clog2(DEPTH);
    localparam logic [32:0] SpanBytes = 33'(DEPTH) << 3;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] init_idx_q, init_idx_d;
    logic [63:0]     mem_q [DEPTH];

    logic [31:0]     offset;
    logic [IdxW-1:0] idx;
    logic [2:0]      align_mask;
    logic            legal, fire, mem_we;
    tl_pt_rsp_t      rsp, head;
    logic [1:0]      count;
    logic            unused_param;

    assign unused_param = ^a_param_i;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == StInit) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == IdxW'(DEPTH - 1)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= INIT_ZERO ? StInit : StRun;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Below-base addresses wrap to huge offsets and fall out of range naturally.
    assign offset     = a_address_i - BASE_ADDR;
    assign idx        = IdxW'(offset >> 3);
    assign align_mask = 3'((4'd1 << a_size_i[1:0]) - 4'd1);
    assign legal      = ({1'b0, offset} < SpanBytes) && (a_size_i <= 4'd3)
                        && ((a_address_i[2:0] & align_mask) == 3'b000);

    assign a_ready_o = (state_q == StRun) && (count < 2'd2);
    assign fire      = a_valid_i && a_ready_o;

    always_comb begin
        rsp        = '0;
        rsp.size   = a_size_i;
        rsp.source = a_source_i;
        mem_we     = 1'b0;
        case (a_opcode_i)
            AOpPutFull, AOpPutPartial: begin
                rsp.opcode = DOpAccessAck;
                rsp.denied = ~legal;
                mem_we     = fire && legal && !a_corrupt_i && !reset_i;
            end
            AOpArith, AOpLogic: begin
                rsp.opcode  = DOpAccessAckData;
                rsp.denied  = 1'b1;
                rsp.corrupt = 1'b1;
            end
            AOpGet: begin
                rsp.opcode = DOpAccessAckData;
                if (legal) begin
                    rsp.data = mem_q[idx];
                end else begin
                    rsp.denied  = 1'b1;
                    rsp.corrupt = 1'b1;
                end
            end
            AOpIntent: begin
                rsp.opcode = DOpHintAck;
            end
            default: begin
                rsp.opcode = DOpAccessAck;
                rsp.denied = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (state_q == StInit) begin
            mem_q[init_idx_q] <= '0;
        end else if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (a_mask_i[b]) begin
                    mem_q[idx][8*b +: 8] <= a_data_i[8*b +: 8];
                end
            end
        end
    end

    tl_pt_resp_queue u_resp_queue (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .push_i  (fire),
        .pop_i   (d_valid_o && d_ready_i),
        .data_i  (rsp),
        .head_o  (head),
        .count_o (count)
    );

    assign d_valid_o   = (count != 2'd0);
    assign d_opcode_o  = head.opcode;
    assign d_param_o   = 2'b00;
    assign d_size_o    = head.size;
    assign d_source_o  = head.source;
    assign d_sink_o    = 3'b000;
    assign d_denied_o  = head.denied;
    assign d_data_o    = head.data;
    assign d_corrupt_o = head.corrupt;
    assign init_done_o = (state_q == StRun);

endmodule

// File: tb/tb_tl_punchthrough_responder.sv
// Directed self-checking bench for tl_punchthrough_responder (DEPTH=16, zero-fill on reset).
module tb_tl_punchthrough_responder;

    localparam logic [2:0] PutFull = 3'd0, PutPart = 3'd1, Arith = 3'd2, Logic = 3'd3;
    localparam logic [2:0] Get = 3'd4, Intent = 3'd5;
    localparam logic [2:0] Ack = 3'd0, AckData = 3'd1, HintAck = 3'd2;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, a_corrupt;
    logic [2:0]  a_opcode, a_param;
    logic [3:0]  a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        d_valid, d_ready, d_denied, d_corrupt, init_done;
    logic [2:0]  d_opcode, d_sink;
    logic [1:0]  d_param, d_source;
    logic [3:0]  d_size;
    logic [63:0] d_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    tl_punchthrough_responder #(
        .BASE_ADDR (32'h8000_0000),
        .DEPTH     (16),
        .INIT_ZERO (1'b1)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_opcode_i  (a_opcode),
        .a_param_i   (a_param),
        .a_size_i    (a_size),
        .a_source_i  (a_source),
        .a_address_i (a_address),
        .a_mask_i    (a_mask),
        .a_data_i    (a_data),
        .a_corrupt_i (a_corrupt),
        .d_valid_o   (d_valid),
        .d_ready_i   (d_ready),
        .d_opcode_o  (d_opcode),
        .d_param_o   (d_param),
        .d_size_o    (d_size),
        .d_source_o  (d_source),
        .d_sink_o    (d_sink),
        .d_denied_o  (d_denied),
        .d_data_o    (d_data),
        .d_corrupt_o (d_corrupt),
        .init_done_o (init_done)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hdr(input logic [2:0] op, input logic [3:0] sz,
                                        input logic [1:0] src, input logic den,
                                        input logic cor);
        return {op, 2'b00, sz, src, 3'b000, den, cor};
    endfunction

    function automatic logic [15:0] obs_hdr();
        return {d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_corrupt};
    endfunction

    task automatic drive(input logic [2:0] op, input logic [3:0] size, input logic [1:0] src,
                         input logic [31:0] addr, input logic [7:0] mask,
                         input logic [63:0] data, input logic cor);
        a_opcode  = op;
        a_size    = size;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_corrupt = cor;
        a_valid   = 1'b1;
    endtask

    // Single request then its response, with d_ready high; the response must be
    // visible in the cycle right after the accept edge.
    task automatic xact(input string tag, input logic [2:0] op, input logic [3:0] size,
                        input logic [1:0] src, input logic [31:0] addr,
                        input logic [7:0] mask, input logic [63:0] data, input logic cor,
                        input logic [2:0] eop, input logic eden, input logic ecor,
                        input logic [63:0] edata);
        int n = 0;
        drive(op, size, src, addr, mask, data, cor);
        while (!a_ready && n < 50) begin
            n++;
            @(posedge clock); #1;
        end
        if (!a_ready) begin
            check_eq({tag, "_accept"}, a_ready, 1);
            a_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        a_valid = 1'b0;
        check_eq({tag, "_dvalid"}, d_valid, 1);
        check_eq({tag, "_hdr"}, obs_hdr(), hdr(eop, size, src, eden, ecor));
        check_eq({tag, "_data"}, d_data, edata);
        @(posedge clock); #1;
    endtask

    initial begin
        int  n;
        bit  seen;
        reset   = 1'b1;
        a_valid = 1'b0;
        a_param = 3'd0;
        d_ready = 1'b1;
        drive(Get, 4'd3, 2'd0, 32'h8000_0000, 8'h00, 64'h0, 1'b0);
        a_valid = 1'b0;

        @(posedge clock); #1;
        check_eq("rst_a_ready", a_ready, 0);
        check_eq("rst_d_valid", d_valid, 0);
        check_eq("rst_init_done", init_done, 0);
        check_eq("rst_d_hdr", obs_hdr(), 16'h0);
        check_eq("rst_d_data", d_data, 64'h0);
        reset = 1'b0;

        n = 0;
        while (!a_ready && n < 100) begin
            n++;
            @(posedge clock); #1;
        end
        check_eq("init_cycles", n, 16);
        check_eq("init_done", init_done, 1);

        xact("get_zero", Get, 4'd3, 2'd2, 32'h8000_0040, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);
        xact("put_full", PutFull, 4'd3, 2'd1, 32'h8000_0008, 8'hFF,
             64'h1122_3344_5566_7788, 1'b0, Ack, 1'b0, 1'b0, 64'h0);
        xact("put_part", PutPart, 4'd3, 2'd1, 32'h8000_0008, 8'h0F,
             64'hAAAA_AAAA_AAAA_AAAA, 1'b0, Ack, 1'b0, 1'b0, 64'h0);
        xact("get_w1", Get, 4'd3, 2'd3, 32'h8000_0008, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h1122_3344_AAAA_AAAA);
        xact("get_sz2", Get, 4'd2, 2'd0, 32'h8000_000C, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h1122_3344_AAAA_AAAA);
        xact("put_w2", PutFull, 4'd3, 2'd0, 32'h8000_0010, 8'hFF, 64'h2222, 1'b0,
             Ack, 1'b0, 1'b0, 64'h0);

        // Put then Get to the same word on consecutive edges.
        drive(PutFull, 4'd3, 2'd0, 32'h8000_0018, 8'hFF, 64'h3333, 1'b0);
        check_eq("rw_rdy0", a_ready, 1);
        @(posedge clock); #1;
        drive(Get, 4'd3, 2'd1, 32'h8000_0018, 8'h00, 64'h0, 1'b0);
        check_eq("rw_rdy1", a_ready, 1);
        @(posedge clock); #1;
        a_valid = 1'b0;
        check_eq("rw_hdr", obs_hdr(), hdr(AckData, 4'd3, 2'd1, 1'b0, 1'b0));
        check_eq("rw_data", d_data, 64'h3333);
        @(posedge clock); #1;
        check_eq("rw_drain", d_valid, 0);

        // Backpressure: two responses fill the queue, third request waits.
        d_ready = 1'b0;
        drive(Get, 4'd3, 2'd0, 32'h8000_0008, 8'h00, 64'h0, 1'b0);
        check_eq("bp_rdy0", a_ready, 1);
        @(posedge clock); #1;
        check_eq("bp_dv1", d_valid, 1);
        drive(Get, 4'd3, 2'd1, 32'h8000_0040, 8'h00, 64'h0, 1'b0);
        check_eq("bp_rdy1", a_ready, 1);
        @(posedge clock); #1;
        check_eq("bp_full", a_ready, 0);
        drive(Get, 4'd3, 2'd2, 32'h8000_0010, 8'h00, 64'h0, 1'b0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check_eq("bp_hold", a_ready, 0);
        check_eq("bp_head_src", d_source, 2'd0);
        check_eq("bp_head_data", d_data, 64'h1122_3344_AAAA_AAAA);
        d_ready = 1'b1;
        @(posedge clock); #1;
        check_eq("bp_reopen", a_ready, 1);
        check_eq("bp_second_src", d_source, 2'd1);
        check_eq("bp_second_data", d_data, 64'h0);
        @(posedge clock); #1;
        a_valid = 1'b0;
        check_eq("bp_third_dv", d_valid, 1);
        check_eq("bp_third_src", d_source, 2'd2);
        check_eq("bp_third_data", d_data, 64'h2222);
        @(posedge clock); #1;
        check_eq("bp_drain", d_valid, 0);

        // Illegal accesses and boundaries.
        xact("get_below", Get, 4'd3, 2'd1, 32'h7FFF_FFF8, 8'h00, 64'h0, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("get_misal", Get, 4'd3, 2'd1, 32'h8000_0004, 8'h00, 64'h0, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("get_size4", Get, 4'd4, 2'd1, 32'h8000_0008, 8'h00, 64'h0, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("get_top", Get, 4'd3, 2'd1, 32'h8000_0080, 8'h00, 64'h0, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("get_last", Get, 4'd3, 2'd1, 32'h8000_0078, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);
        xact("put_misal", PutFull, 4'd3, 2'd0, 32'h8000_0004, 8'hFF,
             64'hDEAD_BEEF_DEAD_BEEF, 1'b0, Ack, 1'b1, 1'b0, 64'h0);
        xact("put_oob", PutFull, 4'd3, 2'd0, 32'h8000_0080, 8'hFF,
             64'hDEAD_BEEF_DEAD_BEEF, 1'b0, Ack, 1'b1, 1'b0, 64'h0);
        xact("put_corrupt", PutFull, 4'd3, 2'd0, 32'h8000_0040, 8'hFF,
             64'hBEEF_BEEF_BEEF_BEEF, 1'b1, Ack, 1'b0, 1'b0, 64'h0);
        xact("chk_w0", Get, 4'd3, 2'd0, 32'h8000_0000, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);
        xact("chk_w8", Get, 4'd3, 2'd0, 32'h8000_0040, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);

        // Unsupported and hint opcodes.
        xact("op_logic", Logic, 4'd3, 2'd1, 32'h8000_0008, 8'hFF, 64'h5, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("op_arith", Arith, 4'd2, 2'd2, 32'h8000_0008, 8'hFF, 64'h5, 1'b0,
             AckData, 1'b1, 1'b1, 64'h0);
        xact("op_intent", Intent, 4'd3, 2'd2, 32'h7000_0001, 8'h00, 64'h0, 1'b0,
             HintAck, 1'b0, 1'b0, 64'h0);
        xact("op_7", 3'd7, 4'd3, 2'd3, 32'h8000_0008, 8'hFF, 64'h9, 1'b0,
             Ack, 1'b1, 1'b0, 64'h0);
        xact("op_6", 3'd6, 4'd1, 2'd0, 32'h8000_0008, 8'hFF, 64'h9, 1'b0,
             Ack, 1'b1, 1'b0, 64'h0);
        xact("chk_w1", Get, 4'd3, 2'd0, 32'h8000_0008, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h1122_3344_AAAA_AAAA);

        // Reset with two responses pending.
        d_ready = 1'b0;
        drive(Get, 4'd3, 2'd1, 32'h8000_0008, 8'h00, 64'h0, 1'b0);
        @(posedge clock); #1;
        drive(Get, 4'd3, 2'd2, 32'h8000_0010, 8'h00, 64'h0, 1'b0);
        @(posedge clock); #1;
        a_valid = 1'b0;
        check_eq("rq_queued_dv", d_valid, 1);
        check_eq("rq_queued_full", a_ready, 0);
        reset = 1'b1;
        @(posedge clock); #1;
        check_eq("rq_flush_dv", d_valid, 0);
        check_eq("rq_flush_done", init_done, 0);
        reset   = 1'b0;
        d_ready = 1'b1;
        seen    = 1'b0;
        n       = 0;
        while (!a_ready && n < 100) begin
            if (d_valid) seen = 1'b1;
            n++;
            @(posedge clock); #1;
        end
        check_eq("rq_init_cycles", n, 16);
        check_eq("rq_stale", seen, 0);
        check_eq("rq_idle_dv", d_valid, 0);
        xact("rq_cleared_w1", Get, 4'd3, 2'd1, 32'h8000_0008, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);
        xact("rq_cleared_w2", Get, 4'd3, 2'd2, 32'h8000_0010, 8'h00, 64'h0, 1'b0,
             AckData, 1'b0, 1'b0, 64'h0);
        check_eq("rq_empty", d_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
